port_rd_frontend: RTL

Per-output-port read frontend. It is the egress counterpart of the port write frontend.
- Picks one of 8 priority queues for the port, using strict priority or weighted round robin.
- Requests one packet dequeue from the SRAM side, buffers the returned word stream in a small FIFO, and drives the external rd_sop/rd_vld/rd_data/rd_eop interface under downstream ready.
- Instantiated 16 times, one per port, between the SRAM read datapath and the top-level rd_* pins.

---
 rtl/port_rd_frontend.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/port_rd_frontend.sv
// port_rd_frontend
//   Egress read frontend for one output port. It arbitrates among the
//   port's 8 priority queues and issues one dequeue request at a time to the
//   SRAM side. Returned words are buffered in a small FIFO, and the
//   rd_sop/rd_vld/rd_data/rd_eop stream is driven out under downstream ready.
//
// Optional build macro:
//   RD_PREFETCH_EN - when defined, the request side does not wait for rd_eop
//                    before issuing the next dequeue. Several packets may then
//                    sit in the FIFO, and they are separated by the last flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wrr_enable          1 = weighted round robin, 0 = strict priority
//   queue_nonempty[7:0] per-priority "has a packet" flags (0 = highest)
//   deq_req/deq_prior   dequeue request and selected queue, held until deq_ack
//   deq_ack             SRAM side accepted the request
//   xfer_data_vld/xfer_data/xfer_end_of_packet
//                       returned word stream
//   xfer_pause          backpressure when free FIFO entries <= PAUSE_LEVEL
//   ready               downstream ready
//   rd_sop/rd_vld/rd_data/rd_eop
//                       egress stream (registered, never two strobes at once)
//   overflow_err        sticky: a word arrived while the FIFO was full
module port_rd_frontend #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PAUSE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrr_enable,
    input  logic [7:0]        queue_nonempty,
    output logic              deq_req,
    output logic [2:0]        deq_prior,
    input  logic              deq_ack,
    input  logic              xfer_data_vld,
    input  logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_end_of_packet,
    output logic              xfer_pause,
    input  logic              ready,
    output logic              rd_sop,
    output logic              rd_eop,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_RECV,
        R_WAIT
    } req_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_SOP,
        O_DATA,
        O_EOP
    } out_state_t;

    // WRR reload weight: queue 0 gets 8 grants per round, queue 7 gets 1.
    function automatic logic [3:0] reload_val(input logic [2:0] p);
        return 4'd8 - {1'b0, p};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_state_t        r_state_q, r_state_d;
    out_state_t        o_state_q, o_state_d;

    logic              deq_req_q, deq_req_d;
    logic [2:0]        deq_prior_q, deq_prior_d;
    logic [3:0]        credit_q [8];
    logic [3:0]        credit_d [8];

    logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              xfer_pause_q, xfer_pause_d;
    logic              overflow_q, overflow_d;

    logic              rd_sop_q, rd_sop_d;
    logic              rd_eop_q, rd_eop_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [7:0]        eligible;
    logic [7:0]        cand;
    logic              credit_reload;
    logic [2:0]        grant;
    logic              found;

    always_comb begin
        eligible      = '0;
        cand          = '0;
        credit_reload = 1'b0;
        grant         = '0;
        found         = 1'b0;
        for (int unsigned p = 0; p < 8; p++) begin
            eligible[p] = queue_nonempty[p] && (credit_q[p] != '0);
        end
        // With WRR, a round ends when no waiting queue has credit left; the
        // reload and the grant from the reloaded values share one cycle.
        if (wrr_enable && (eligible == '0)) begin
            credit_reload = 1'b1;
        end
        if (!wrr_enable || credit_reload) begin
            cand = queue_nonempty;
        end else begin
            cand = eligible;
        end
        for (int unsigned p = 0; p < 8; p++) begin
            if (cand[p] && !found) begin
                grant = 3'(p);
                found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   pop_word;

    assign push_req   = (r_state_q == R_RECV) && xfer_data_vld;
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop_word   = fifo_mem_q[rd_ptr_q];
    assign pop        = ((o_state_q == O_SOP) || (o_state_q == O_DATA)) &&
                        ready && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only dropped when nothing leaves.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        xfer_pause_d = ((CNT_W'(FIFO_DEPTH) - count_d) <= CNT_W'(PAUSE_LEVEL));
    end

    // ------------------------------------------------------------------
    // Request FSM (with WRR credit update at grant)
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d   = r_state_q;
        deq_req_d   = deq_req_q;
        deq_prior_d = deq_prior_q;
        credit_d    = credit_q;

        case (r_state_q)
            R_IDLE: begin
                if (queue_nonempty != '0) begin
                    deq_prior_d = grant;
                    deq_req_d   = 1'b1;
                    r_state_d   = R_REQ;
                    if (wrr_enable) begin
                        if (credit_reload) begin
                            for (int unsigned p = 0; p < 8; p++) begin
                                credit_d[p] = reload_val(3'(p));
                            end
                            credit_d[grant] = reload_val(grant) - 4'd1;
                        end else begin
                            credit_d[grant] = credit_q[grant] - 4'd1;
                        end
                    end
                end
            end
            R_REQ: begin
                if (deq_ack) begin
                    deq_req_d = 1'b0;
                    r_state_d = R_RECV;
                end
            end
            R_RECV: begin
                // The end-of-packet word closes the request even if it was
                // dropped on overflow, so the request side cannot stall here.
                if (xfer_data_vld && xfer_end_of_packet) begin
`ifdef RD_PREFETCH_EN
                    r_state_d = R_IDLE;
`else
                    r_state_d = R_WAIT;
`endif
                end
            end
            R_WAIT: begin
                if (rd_eop_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    logic data_avail;

    // An incoming push counts as available so rd_sop follows the first push
    // by a single cycle.
    assign data_avail = !fifo_empty || push_req;

    always_comb begin
        o_state_d = o_state_q;
        rd_sop_d  = 1'b0;
        rd_eop_d  = 1'b0;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;

        case (o_state_q)
            O_IDLE: begin
                if (data_avail) begin
                    rd_sop_d  = 1'b1;
                    o_state_d = O_SOP;
                end
            end
            // O_SOP is the cycle rd_sop is visible; popping is already
            // allowed there so the first rd_vld directly follows rd_sop.
            O_SOP, O_DATA: begin
                o_state_d = O_DATA;
                if (pop) begin
                    rd_vld_d  = 1'b1;
                    rd_data_d = pop_word[DATA_W-1:0];
                    if (pop_word[DATA_W]) begin
                        o_state_d = O_EOP;
                    end
                end
            end
            // O_EOP is the cycle the last rd_vld is visible. rd_eop appears
            // next, while in O_IDLE, and a following packet's rd_sop comes
            // right after it.
            O_EOP: begin
                rd_eop_d  = 1'b1;
                o_state_d = O_IDLE;
            end
            default: o_state_d = O_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            o_state_q    <= O_IDLE;
            deq_req_q    <= 1'b0;
            deq_prior_q  <= '0;
            for (int unsigned p = 0; p < 8; p++) begin
                credit_q[p] <= reload_val(3'(p));
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            xfer_pause_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            r_state_q    <= r_state_d;
            o_state_q    <= o_state_d;
            deq_req_q    <= deq_req_d;
            deq_prior_q  <= deq_prior_d;
            credit_q     <= credit_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            xfer_pause_q <= xfer_pause_d;
            overflow_q   <= overflow_d;
            rd_sop_q     <= rd_sop_d;
            rd_eop_q     <= rd_eop_d;
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {xfer_end_of_packet, xfer_data};
        end
    end

    assign deq_req      = deq_req_q;
    assign deq_prior    = deq_prior_q;
    assign xfer_pause   = xfer_pause_q;
    assign overflow_err = overflow_q;
    assign rd_sop       = rd_sop_q;
    assign rd_eop       = rd_eop_q;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = rd_data_q;

endmodule
